// File: rtl/ram_bus_bridge.sv
// Bridge from the picorv32 native memory bus to a single-port synchronous word RAM.
// Every transfer takes two cycles: the RAM access happens in the accept cycle and mem_ready pulses in the next.
module ram_bus_bridge #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_valid_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  input  logic [3:0]            mem_wstrb_i,
  output logic                  mem_ready_o,
  output logic [31:0]           mem_rdata_o,
  output logic                  ram_ce_o,
  output logic [3:0]            ram_wr_o,
  output logic [31:0]           ram_d_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [31:0]           ram_q_i,
  output logic                  bus_err_o,
  output logic [31:0]           err_addr_o
);

  typedef enum logic {
    IDLE,
    ACK
  } state_e;

  // The window size is 33 bits wide, so the comparison stays correct even for the largest ADDR_WIDTH.
  localparam logic [32:0] WINDOW_BYTES = 33'd4 << ADDR_WIDTH;

  state_e      state_q, state_d;
  logic        is_err_q, is_err_d;
  logic        is_read_q, is_read_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] off;
  logic        in_window;
  logic        accept;

  // The offset wraps, so an address below ADDR_BASE becomes large and falls outside the window.
  assign off        = mem_addr_i - ADDR_BASE;
  assign in_window  = ({1'b0, off} < WINDOW_BYTES);
  assign ram_addr_o = off[ADDR_WIDTH+1:2];
  assign ram_d_o    = mem_wdata_i;
  assign ram_wr_o   = ram_ce_o ? mem_wstrb_i : 4'h0;
  assign bus_err_o  = bus_err_q;
  assign err_addr_o = err_addr_q;

  always_comb begin
    state_d     = state_q;
    is_err_d    = is_err_q;
    is_read_d   = is_read_q;
    bus_err_d   = bus_err_q;
    err_addr_d  = err_addr_q;
    accept      = 1'b0;
    ram_ce_o    = 1'b0;
    mem_ready_o = 1'b0;
    mem_rdata_o = 32'h0;

    case (state_q)
      IDLE: begin
        if (mem_valid_i) begin
          accept    = 1'b1;
          ram_ce_o  = in_window;
          is_err_d  = !in_window;
          is_read_d = (mem_wstrb_i == 4'h0);
          state_d   = ACK;
        end
      end
      ACK: begin
        mem_ready_o = 1'b1;
        if (is_read_q) begin
          mem_rdata_o = is_err_q ? ERR_DATA : ram_q_i;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Only the first bad address is kept; later errors leave err_addr unchanged.
    if (accept && !in_window) begin
      bus_err_d = 1'b1;
      if (!bus_err_q) begin
        err_addr_d = mem_addr_i;
      end
    end

    if (rst_i) begin
      ram_ce_o    = 1'b0;
      mem_ready_o = 1'b0;
      mem_rdata_o = 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      is_err_q   <= 1'b0;
      is_read_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      is_err_q   <= is_err_d;
      is_read_q  <= is_read_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Directed bench for ram_bus_bridge. It uses a behavioural RAM and a scoreboard queue of expected read data.
module tb_ram_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        memValid, memValid2;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memWstrb;
  logic        memReady, memReady2;
  logic [31:0] memRdata, memRdata2;
  logic        ramCe, ramCe2;
  logic [3:0]  ramWr, ramWr2;
  logic [31:0] ramD, ramD2;
  logic [15:0] ramAddr, ramAddr2;
  logic [31:0] ramQ;
  logic [31:0] ramQ2 = 32'h0;
  logic        busErr, busErr2;
  logic [31:0] errAddr, errAddr2;

  logic [31:0] ramArray [0:65535];
  logic [31:0] expQ [$];
  logic [31:0] sbMem [int];
  logic        expBusErr;
  logic [31:0] expErrAddr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ram_bus_bridge dut (
    .clk_i(clk), .rst_i(rst), .mem_valid_i(memValid), .mem_addr_i(memAddr),
    .mem_wdata_i(memWdata), .mem_wstrb_i(memWstrb), .mem_ready_o(memReady),
    .mem_rdata_o(memRdata), .ram_ce_o(ramCe), .ram_wr_o(ramWr), .ram_d_o(ramD),
    .ram_addr_o(ramAddr), .ram_q_i(ramQ), .bus_err_o(busErr), .err_addr_o(errAddr)
  );

  ram_bus_bridge #(.ADDR_BASE(32'h0000_1000)) dut2 (
    .clk_i(clk), .rst_i(rst), .mem_valid_i(memValid2), .mem_addr_i(memAddr),
    .mem_wdata_i(memWdata), .mem_wstrb_i(memWstrb), .mem_ready_o(memReady2),
    .mem_rdata_o(memRdata2), .ram_ce_o(ramCe2), .ram_wr_o(ramWr2), .ram_d_o(ramD2),
    .ram_addr_o(ramAddr2), .ram_q_i(ramQ2), .bus_err_o(busErr2), .err_addr_o(errAddr2)
  );

  always_ff @(posedge clk) begin
    if (ramCe) begin
      for (int b = 0; b < 4; b++) begin
        if (ramWr[b]) ramArray[ramAddr][8*b +: 8] <= ramD[8*b +: 8];
      end
      if (ramWr == 4'h0) ramQ <= ramArray[ramAddr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one full transfer: the cycle-A RAM-side checks, then the ACK-cycle checks against the scoreboard.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] off, expData, word;
    logic        inWin;
    int          key;
    @(posedge clk); #1;
    memValid = 1'b1; memAddr = addr; memWdata = wdata; memWstrb = strb;
    off   = addr;
    inWin = (off < 32'h0004_0000);
    key   = int'(off[31:2]);
    if (strb != 4'h0) expData = 32'h0;
    else if (!inWin)  expData = 32'hDEAD_BEEF;
    else              expData = sbMem.exists(key) ? sbMem[key] : 32'h0;
    if (inWin && strb != 4'h0) begin
      word = sbMem.exists(key) ? sbMem[key] : 32'h0;
      for (int b = 0; b < 4; b++) if (strb[b]) word[8*b +: 8] = wdata[8*b +: 8];
      sbMem[key] = word;
    end
    if (!inWin && !expBusErr) expErrAddr = addr;
    if (!inWin) expBusErr = 1'b1;
    expQ.push_back(expData);
    #1;
    checkOutput("A.ram_ce", ramCe, inWin);
    checkOutput("A.ram_wr", ramWr, inWin ? strb : 4'h0);
    if (inWin) checkOutput("A.ram_addr", ramAddr, off[17:2]);
    checkOutput("A.ram_d", ramD, wdata);
    checkOutput("A.ready_low", memReady, 1'b0);
    checkOutput("A.rdata_zero", memRdata, 32'h0);
    @(posedge clk); #1;
    checkOutput("ACK.ready", memReady, 1'b1);
    checkOutput("ACK.ram_ce", ramCe, 1'b0);
    checkOutput("ACK.rdata", memRdata, expQ.pop_front());
    checkOutput("ACK.bus_err", busErr, expBusErr);
    checkOutput("ACK.err_addr", errAddr, expErrAddr);
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
    memValid = 1'b0; memValid2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; memValid = 1'b1; memValid2 = 1'b0;
    memAddr = 32'h100; memWdata = 32'h0; memWstrb = 4'hF;
    expBusErr = 1'b0; expErrAddr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.ram_ce", ramCe, 1'b0);
    checkOutput("rst.ram_wr", ramWr, 4'h0);
    checkOutput("rst.ready", memReady, 1'b0);
    checkOutput("rst.rdata", memRdata, 32'h0);
    checkOutput("rst.bus_err", busErr, 1'b0);
    checkOutput("rst.err_addr", errAddr, 32'h0);
    memValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] full write and read-back");
    applyStimulus(32'h0000_0100, 32'h1234_5678, 4'hF);
    applyStimulus(32'h0000_0100, 32'h0, 4'h0);
    idleCycle();

    $display("[TB] partial strobe write");
    applyStimulus(32'h0000_0100, 32'hAAAA_BBCC, 4'b0010);
    applyStimulus(32'h0000_0100, 32'h0, 4'h0);
    idleCycle();

    $display("[TB] top word of window");
    applyStimulus(32'h0003_FFFC, 32'hCAFE_F00D, 4'hF);
    applyStimulus(32'h0003_FFFC, 32'h0, 4'h0);
    idleCycle();

    $display("[TB] back-to-back read, read, write");
    applyStimulus(32'h0000_0100, 32'h0, 4'h0);
    applyStimulus(32'h0003_FFFC, 32'h0, 4'h0);
    applyStimulus(32'h0000_0300, 32'h0BAD_CAFE, 4'b1001);
    idleCycle();

    $display("[TB] out-of-window reads");
    applyStimulus(32'h0004_0000, 32'h0, 4'h0);
    applyStimulus(32'h0005_0000, 32'h0, 4'h0);
    idleCycle();

    $display("[TB] reset during ACK of a write");
    @(posedge clk); #1;
    memValid = 1'b1; memAddr = 32'h200; memWdata = 32'h5A5A_0F0F; memWstrb = 4'hF;
    #1;
    checkOutput("rstop.A.ram_ce", ramCe, 1'b1);
    sbMem[32'h80] = 32'h5A5A_0F0F;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("rstop.ACK.ready", memReady, 1'b0);
    checkOutput("rstop.ACK.rdata", memRdata, 32'h0);
    @(posedge clk); #1;
    checkOutput("rstop.hold.ram_ce", ramCe, 1'b0);
    checkOutput("rstop.bus_err", busErr, 1'b0);
    checkOutput("rstop.err_addr", errAddr, 32'h0);
    rst = 1'b0; memValid = 1'b0;
    expBusErr = 1'b0; expErrAddr = 32'h0;
    applyStimulus(32'h0000_0200, 32'h0, 4'h0);
    applyStimulus(32'h0000_0300, 32'h0, 4'h0);
    idleCycle();

    $display("[TB] nonzero ADDR_BASE instance");
    @(posedge clk); #1;
    memValid2 = 1'b1; memAddr = 32'h1000; memWdata = 32'h11; memWstrb = 4'hF;
    #1;
    checkOutput("d2.in.ram_ce", ramCe2, 1'b1);
    checkOutput("d2.in.ram_addr", ramAddr2, 32'h0);
    @(posedge clk); #1;
    checkOutput("d2.in.ready", memReady2, 1'b1);
    checkOutput("d2.in.rdata", memRdata2, 32'h0);
    checkOutput("d2.in.bus_err", busErr2, 1'b0);
    @(posedge clk); #1;
    memAddr = 32'h0FFC; memWstrb = 4'h0;
    #1;
    checkOutput("d2.out.ram_ce", ramCe2, 1'b0);
    @(posedge clk); #1;
    checkOutput("d2.out.ready", memReady2, 1'b1);
    checkOutput("d2.out.rdata", memRdata2, 32'hDEAD_BEEF);
    checkOutput("d2.out.bus_err", busErr2, 1'b1);
    checkOutput("d2.out.err_addr", errAddr2, 32'h0000_0FFC);
    idleCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
